arm_control_seq_master: RTL and testbench
=========================================

ARM_CONTROL_SEQ_MASTER -- requirements
Module: arm_control_seq_master

Interface
- REQ-001 SHALL have parameter C_M00_AXI_ADDR_WIDTH, default 32, AXI4-Lite address width.
- REQ-002 SHALL have parameter C_M00_AXI_DATA_WIDTH, default 32, data width (fixed 32 in this release).
- REQ-003 SHALL have parameter C_NUM_REGS, default 4, registers exercised (1..16).
- REQ-004 SHALL have parameter C_BASE_ADDR, default 32'h0000_0000, first register address.
- REQ-005 SHALL have parameter C_START_DATA, default 32'h0000_0001, first write value.
- REQ-006 SHALL have one clock and a synchronous, active-low reset.
- REQ-007 SHALL have m00_axi_aclk, input, 1, clock.
- REQ-008 SHALL have m00_axi_aresetn, input, 1, reset, synchronous, active-low.
- REQ-009 SHALL have start, input, 1, single-cycle pulse that launches a test pass.
- REQ-010 SHALL have busy (output, 1, pass in progress), done (output, 1, one-cycle end pulse), error (output, 1, sticky fail flag) and err_count (output, 8, mismatch count).
- REQ-011 SHALL have the AXI4-Lite master ports m00_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready with standard directions and widths.

Function
- REQ-012 SHALL drive awprot = arprot = 3'b000 and wstrb = 4'hF at all times.
- REQ-013 SHALL use states IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE, with index i counting 0..C_NUM_REGS-1.
- REQ-014 SHALL move IDLE -> WR when start=1, clearing i, error and err_count in that cycle; start in any other state SHALL be ignored.
- REQ-015 WR: SHALL assert awvalid and wvalid together on the first WR cycle, with awaddr = C_BASE_ADDR + 4*i and wdata = C_START_DATA + i (mod 2^32).
- REQ-016 SHALL drop each of awvalid and wvalid in the cycle after its own handshake, independently; awaddr/wdata SHALL stay stable while the matching valid is high.
- REQ-017 SHALL enter WR_RESP once both handshakes are complete, in any order or simultaneously, and hold bready=1 only in WR_RESP.
- REQ-018 On a B handshake, bresp != 2'b00 SHALL increment err_count; then i+1 -> WR, or, if i was the last index, i=0 -> RD_ADDR.
- REQ-019 RD_ADDR: SHALL assert arvalid with araddr = C_BASE_ADDR + 4*i until arready, then go to RD_DATA.
- REQ-020 RD_DATA: SHALL hold rready=1; on an R handshake, rdata != C_START_DATA + i or rresp != 2'b00 SHALL increment err_count by 1 only, even if both are wrong; then next i -> RD_ADDR, or after the last index -> DONE.
- REQ-021 err_count SHALL saturate at 8'hFF; error SHALL equal (err_count != 0).
- REQ-022 DONE SHALL last exactly one cycle, with done=1, then go to IDLE; busy SHALL be 1 in every state except IDLE.
- REQ-023 SHALL have at most one outstanding transaction at a time; no read is issued before the final write response.
- REQ-024 SHALL not time out; a slave that never responds leaves the block in its current state.

Reset
- REQ-025 With m00_axi_aresetn=0 on a rising edge, the block SHALL go to IDLE with i=0, all valid/ready outputs 0, busy=0, done=0, error=0, err_count=0, and awaddr/araddr/wdata = 0.
- REQ-026 Reset mid-transaction SHALL apply REQ-025 on the next edge; a later start SHALL begin a fresh pass from index 0.

Verification
- REQ-027 Zero-wait memory slave, start pulse -> writes 1,2,3,4 to 0x0,0x4,0x8,0xC, then reads in the same order, done pulses once, error=0, err_count=0.
- REQ-028 Slave returns 32'hDEADBEEF at 0x8 -> err_count=1, error=1 at done; the other three reads pass.
- REQ-029 BRESP=2'b10 on write to 0x4 and RRESP=2'b10 with wrong data at 0xC -> err_count=2.
- REQ-030 AWREADY delayed 3 cycles after WREADY, and separately WREADY delayed after AWREADY -> each valid drops alone after its handshake; exactly one B wait per write; stored data correct.
- REQ-031 Reset pulled low while awvalid=1 on the second write -> next cycle all valids 0 and busy=0; a new start restarts at 0x0 with data 1.
- REQ-032 Start pulsed again while busy=1 -> ignored; transaction count stays 2*C_NUM_REGS and there is one done pulse.

Source files
------------

// File: rtl/arm_control_seq_master_if.sv
// AXI4-Lite bus bundle between the write/read-back sequencer and the register slave under test.
interface arm_control_seq_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/arm_control_seq_master.sv
// Register self-test master: writes an incrementing pattern to C_NUM_REGS registers over
// AXI4-Lite, reads them back in order and counts bad responses or data mismatches.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start
// S_WR      | AW and W offered for register i, each dropped after its handshake
// S_WR_RESP | bready high, waiting for the write response of register i
// S_RD_ADDR | arvalid high for register i
// S_RD_DATA | rready high, waiting for read data of register i
// S_DONE    | single-cycle done pulse
module arm_control_seq_master #(
    parameter int unsigned C_M00_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M00_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_NUM_REGS           = 4,
    parameter logic [31:0] C_BASE_ADDR          = 32'h0000_0000,
    parameter logic [31:0] C_START_DATA         = 32'h0000_0001
) (
    input  logic                            m00_axi_aclk,
    input  logic                            m00_axi_aresetn,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [7:0]                      err_count,
    arm_control_seq_master_if.master        m00_axi
);
    localparam int unsigned AW = C_M00_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M00_AXI_DATA_WIDTH;
    localparam logic [3:0]  LAST_IDX = 4'(C_NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_idx;
    logic            r_awvalid;
    logic            r_wvalid;
    logic            r_aw_done;
    logic            r_w_done;
    logic            r_arvalid;
    logic [AW-1:0]   r_awaddr;
    logic [AW-1:0]   r_araddr;
    logic [DW-1:0]   r_wdata;
    logic [7:0]      r_err_count;

    logic            w_aw_hs;
    logic            w_w_hs;
    logic            w_ar_hs;
    logic            w_last;
    logic            w_err_inc;
    logic [3:0]      w_idx_inc;

    function automatic logic [AW-1:0] f_addr(input logic [3:0] idx);
        return AW'(C_BASE_ADDR) + AW'({idx, 2'b00});
    endfunction

    function automatic logic [DW-1:0] f_data(input logic [3:0] idx);
        return DW'(C_START_DATA) + DW'(idx);
    endfunction

    assign w_aw_hs   = r_awvalid & m00_axi.awready;
    assign w_w_hs    = r_wvalid & m00_axi.wready;
    assign w_ar_hs   = r_arvalid & m00_axi.arready;
    assign w_last    = (r_idx == LAST_IDX);
    assign w_idx_inc = r_idx + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_err_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_WR;
            end
            S_WR: begin
                // AW and W may complete in either order or together
                if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_state_nxt = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (m00_axi.bvalid) begin
                    w_err_inc   = (m00_axi.bresp != 2'b00);
                    w_state_nxt = w_last ? S_RD_ADDR : S_WR;
                end
            end
            S_RD_ADDR: begin
                if (w_ar_hs) w_state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (m00_axi.rvalid) begin
                    w_err_inc   = (m00_axi.rdata != f_data(r_idx)) | (m00_axi.rresp != 2'b00);
                    w_state_nxt = w_last ? S_DONE : S_RD_ADDR;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge m00_axi_aclk) begin
        if (!m00_axi_aresetn) begin
            r_state     <= S_IDLE;
            r_idx       <= 4'd0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_err_count <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_aw_hs) begin
                r_awvalid <= 1'b0;
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_wvalid <= 1'b0;
                r_w_done <= 1'b1;
            end
            if (w_ar_hs) r_arvalid <= 1'b0;
            if (w_err_inc && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx       <= 4'd0;
                        r_err_count <= 8'd0;
                        r_awvalid   <= 1'b1;
                        r_wvalid    <= 1'b1;
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                        r_awaddr    <= f_addr(4'd0);
                        r_wdata     <= f_data(4'd0);
                    end
                end
                S_WR_RESP: begin
                    if (m00_axi.bvalid) begin
                        if (w_last) begin
                            r_idx     <= 4'd0;
                            r_arvalid <= 1'b1;
                            r_araddr  <= f_addr(4'd0);
                        end else begin
                            r_idx     <= w_idx_inc;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_awaddr  <= f_addr(w_idx_inc);
                            r_wdata   <= f_data(w_idx_inc);
                        end
                    end
                end
                S_RD_DATA: begin
                    if (m00_axi.rvalid) begin
                        if (w_last) begin
                            r_idx <= 4'd0;
                        end else begin
                            r_idx     <= w_idx_inc;
                            r_arvalid <= 1'b1;
                            r_araddr  <= f_addr(w_idx_inc);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign m00_axi.awaddr  = r_awaddr;
    assign m00_axi.awprot  = 3'b000;
    assign m00_axi.awvalid = r_awvalid;
    assign m00_axi.wdata   = r_wdata;
    assign m00_axi.wstrb   = '1;
    assign m00_axi.wvalid  = r_wvalid;
    assign m00_axi.bready  = (r_state == S_WR_RESP);
    assign m00_axi.araddr  = r_araddr;
    assign m00_axi.arprot  = 3'b000;
    assign m00_axi.arvalid = r_arvalid;
    assign m00_axi.rready  = (r_state == S_RD_DATA);

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign error     = (r_err_count != 8'd0);
    assign err_count = r_err_count;
endmodule

// File: tb/tb_arm_control_seq_master.sv
// Bench for the register self-test master: memory slave with programmable ready delays and
// response faults, plus a scoreboard of expected write/read transactions per pass.
module tb_arm_control_seq_master;
    localparam int          N     = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] SDATA = 32'h0000_0001;
    localparam logic [31:0] NONE  = 32'hFFFF_FFFF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy, done, error;
    logic [7:0] err_count;

    arm_control_seq_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    arm_control_seq_master #(
        .C_M00_AXI_ADDR_WIDTH(32), .C_M00_AXI_DATA_WIDTH(32), .C_NUM_REGS(N),
        .C_BASE_ADDR(BASE), .C_START_DATA(SDATA)
    ) dut (
        .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n), .start(start),
        .busy(busy), .done(done), .error(error), .err_count(err_count),
        .m00_axi(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // slave configuration, written only by the main sequence
    int          aw_delay, w_delay;
    logic [31:0] bad_bresp, bad_rdata, bad_rresp;

    // slave state and monitor counters, written only by the slave process
    logic [31:0] mem [16];
    bit          aw_got, w_got, ar_got, b_hs, r_hs;
    bit          aw_hs_p, w_hs_p, ar_hs_p, awv_p, wv_p, arv_p;
    logic [31:0] aw_a, w_d, ar_a, awaddr_p, wdata_p, araddr_p;
    int          aw_cnt, w_cnt;
    int          prot_err = 0, bready_cyc = 0, aw_only = 0, w_only = 0, done_cnt = 0, obs_cnt = 0;
    bit          obs_wr [512];
    logic [31:0] obs_a  [512];
    logic [31:0] obs_d  [512];

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
    } op_t;
    op_t exp_q[$];

    initial begin : slave
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
                aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0; awv_p = 0; wv_p = 0; arv_p = 0;
                aw_cnt = 0; w_cnt = 0;
            end else begin
                if ((aw_hs_p && bus.awvalid) || (w_hs_p && bus.wvalid) || (ar_hs_p && bus.arvalid)) prot_err++;
                if (awv_p && !aw_hs_p && bus.awvalid && bus.awaddr !== awaddr_p) prot_err++;
                if (wv_p && !w_hs_p && bus.wvalid && bus.wdata !== wdata_p) prot_err++;
                if (arv_p && !ar_hs_p && bus.arvalid && bus.araddr !== araddr_p) prot_err++;
                if (bus.arvalid && (aw_got || w_got || bus.bvalid)) prot_err++;
                if (bus.awprot !== 3'b000 || bus.arprot !== 3'b000 || bus.wstrb !== 4'hF) prot_err++;
                if (bus.bready) bready_cyc++;
                if (bus.awvalid && !bus.wvalid) aw_only++;
                if (bus.wvalid && !bus.awvalid) w_only++;
                if (done) done_cnt++;
                aw_hs_p = bus.awvalid && bus.awready;
                w_hs_p  = bus.wvalid && bus.wready;
                ar_hs_p = bus.arvalid && bus.arready;
                b_hs    = bus.bvalid && bus.bready;
                r_hs    = bus.rvalid && bus.rready;
                awv_p = bus.awvalid; wv_p = bus.wvalid; arv_p = bus.arvalid;
                awaddr_p = bus.awaddr; wdata_p = bus.wdata; araddr_p = bus.araddr;
                if (aw_hs_p) begin aw_got = 1; aw_a = bus.awaddr; end
                if (w_hs_p)  begin w_got = 1;  w_d = bus.wdata; end
                if (ar_hs_p) begin ar_got = 1; ar_a = bus.araddr; end
            end
            @(negedge clk);
            if (!rst_n) begin
                bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.arready = 0; bus.rvalid = 0;
            end else begin
                if (b_hs) bus.bvalid = 0;
                if (r_hs) bus.rvalid = 0;
                if (aw_got && w_got && !bus.bvalid) begin
                    mem[aw_a[5:2]] = w_d;
                    bus.bvalid = 1;
                    bus.bresp  = (aw_a == bad_bresp) ? 2'b10 : 2'b00;
                    obs_wr[obs_cnt] = 1; obs_a[obs_cnt] = aw_a; obs_d[obs_cnt] = w_d;
                    if (obs_cnt < 511) obs_cnt++;
                    aw_got = 0; w_got = 0;
                end
                if (ar_got && !bus.rvalid) begin
                    bus.rvalid = 1;
                    bus.rdata  = (ar_a == bad_rdata) ? 32'hDEAD_BEEF : mem[ar_a[5:2]];
                    bus.rresp  = (ar_a == bad_rresp) ? 2'b10 : 2'b00;
                    obs_wr[obs_cnt] = 0; obs_a[obs_cnt] = ar_a; obs_d[obs_cnt] = mem[ar_a[5:2]];
                    if (obs_cnt < 511) obs_cnt++;
                    ar_got = 0;
                end
                if (bus.awvalid && !aw_got) begin bus.awready = (aw_cnt >= aw_delay); aw_cnt++; end
                else begin bus.awready = 0; aw_cnt = 0; end
                if (bus.wvalid && !w_got) begin bus.wready = (w_cnt >= w_delay); w_cnt++; end
                else begin bus.wready = 0; w_cnt = 0; end
                bus.arready = bus.arvalid && !ar_got && !bus.rvalid;
            end
        end
    end

    function automatic int exp_errs();
        int e = 0;
        for (int i = 0; i < N; i++) begin
            if (BASE + 32'(4 * i) == bad_bresp) e++;
            if (BASE + 32'(4 * i) == bad_rdata || BASE + 32'(4 * i) == bad_rresp) e++;
        end
        return e;
    endfunction

    task automatic push_expected();
        for (int i = 0; i < N; i++) exp_q.push_back('{1'b1, BASE + 32'(4 * i), SDATA + 32'(i)});
        for (int i = 0; i < N; i++) exp_q.push_back('{1'b0, BASE + 32'(4 * i), SDATA + 32'(i)});
    endtask

    task automatic run_pass(input bit extra, output bit seen, output int base,
                            output bit busy_s, output logic [7:0] ec_s);
        base = obs_cnt;
        push_expected();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        busy_s = busy;
        ec_s   = err_count;
        seen   = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            start = extra && (k == 3 || k == 12);
            @(negedge clk);
            if (done) seen = 1;
        end
        start = 0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, done, error, err_count} !== 11'd0)
            $display("FAIL reset_status: got %b expected 0", {busy, done, error, err_count});
        else n_pass++;
        n_checks++;
        if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 5'd0)
            $display("FAIL reset_handshake: got %b expected 00000",
                     {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready});
        else n_pass++;
        n_checks++;
        if ({bus.awaddr, bus.wdata, bus.araddr} !== 96'd0)
            $display("FAIL reset_bus: got %h %h %h expected 0", bus.awaddr, bus.wdata, bus.araddr);
        else n_pass++;
        n_checks++;
        if ({bus.awprot, bus.arprot, bus.wstrb} !== 10'b000_000_1111)
            $display("FAIL reset_prot_strb: got %b expected 0000001111", {bus.awprot, bus.arprot, bus.wstrb});
        else n_pass++;
    endtask

    task automatic test_pass(input string name, input int awd, input int wd,
                             input logic [31:0] bb, input logic [31:0] br, input logic [31:0] brr,
                             input bit extra, input bit split_aw, input bit split_w);
        bit seen, busy_s; int base, e, pe0, bc0, ao0, wo0, dc0; logic [7:0] ec_s;
        aw_delay = awd; w_delay = wd; bad_bresp = bb; bad_rdata = br; bad_rresp = brr;
        e = exp_errs();
        pe0 = prot_err; bc0 = bready_cyc; ao0 = aw_only; wo0 = w_only; dc0 = done_cnt;
        run_pass(extra, seen, base, busy_s, ec_s);
        n_checks++;
        if (!seen) $display("FAIL %s done_timeout: done not seen within 400 cycles", name); else n_pass++;
        n_checks++;
        if ({busy_s, ec_s} !== 9'h100) $display("FAIL %s start_state: busy/err_count %b/%0d expected 1/0", name, busy_s, ec_s);
        else n_pass++;
        n_checks++;
        if (obs_cnt - base !== 2 * N) $display("FAIL %s txn_count: got %0d expected %0d", name, obs_cnt - base, 2 * N);
        else n_pass++;
        for (int k = 0; k < 2 * N; k++) begin
            op_t x;
            x = exp_q.pop_front();
            n_checks++;
            if ({obs_wr[base + k], obs_a[base + k], obs_d[base + k]} !== {x.wr, x.a, x.d})
                $display("FAIL %s txn%0d: got wr=%0d a=%h d=%h expected wr=%0d a=%h d=%h", name, k,
                         obs_wr[base + k], obs_a[base + k], obs_d[base + k], x.wr, x.a, x.d);
            else n_pass++;
        end
        n_checks++;
        if ({error, err_count} !== {(e != 0), 8'(e)})
            $display("FAIL %s err: got error=%0d err_count=%0d expected %0d/%0d", name, error, err_count, e != 0, e);
        else n_pass++;
        n_checks++;
        if (done_cnt - dc0 !== 1 || busy !== 1'b0)
            $display("FAIL %s done_pulse: got %0d pulses busy=%0d expected 1 pulse busy=0", name, done_cnt - dc0, busy);
        else n_pass++;
        n_checks++;
        if (bready_cyc - bc0 !== N || prot_err - pe0 !== 0)
            $display("FAIL %s bus_protocol: bready cycles %0d violations %0d expected %0d/0", name,
                     bready_cyc - bc0, prot_err - pe0, N);
        else n_pass++;
        n_checks++;
        if (((aw_only - ao0) >= N) !== split_aw || ((w_only - wo0) >= N) !== split_w)
            $display("FAIL %s valid_split: aw_only %0d w_only %0d expected split aw=%0d w=%0d", name,
                     aw_only - ao0, w_only - wo0, split_aw, split_w);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        aw_delay = 0; w_delay = 0; bad_bresp = NONE; bad_rdata = NONE; bad_rresp = NONE;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (bus.awvalid && bus.awaddr == BASE + 32'd4) found = 1;
            else @(negedge clk);
        end
        n_checks++;
        if (!found) $display("FAIL reset_mid_second_write: awvalid for 0x4 not seen"); else n_pass++;
        rst_n = 0;
        @(negedge clk);
        n_checks++;
        if ({bus.awvalid, bus.wvalid, bus.arvalid, busy} !== 4'd0)
            $display("FAIL reset_mid_idle: got aw/w/ar/busy %b expected 0000", {bus.awvalid, bus.wvalid, bus.arvalid, busy});
        else n_pass++;
        n_checks++;
        if ({bus.awaddr, bus.wdata} !== 64'd0)
            $display("FAIL reset_mid_bus: got %h %h expected 0", bus.awaddr, bus.wdata);
        else n_pass++;
        rst_n = 1;
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        start = 0; rst_n = 0;
        aw_delay = 0; w_delay = 0; bad_bresp = NONE; bad_rdata = NONE; bad_rresp = NONE;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1;
        repeat (2) @(negedge clk);
        test_pass("resp_errors", 0, 0, 32'h4, 32'hC, 32'hC, 0, 0, 0);
        test_pass("basic",       0, 0, NONE, NONE, NONE, 0, 0, 0);
        test_pass("bad_rdata",   0, 0, NONE, 32'h8, NONE, 0, 0, 0);
        test_pass("aw_late",     3, 0, NONE, NONE, NONE, 0, 1, 0);
        test_pass("w_late",      0, 3, NONE, NONE, NONE, 0, 0, 1);
        test_reset_mid();
        test_pass("after_reset", 0, 0, NONE, NONE, NONE, 0, 0, 0);
        test_pass("start_busy",  0, 0, NONE, NONE, NONE, 1, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
